eight_bit: RTL and testbench
============================

# eight_bit

Minimal 8-bit accumulator-less CPU core with a 16×8 register file, 8-bit address space and a single shared bidirectional memory bus using a request/ready handshake. Every instruction is two bytes: an opcode/register byte followed by an operand byte. It is the top-level processor block; memory and I/O sit outside on the `addr`/`data` bus.

## Interface
- No parameters.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `addr`: output, 8 bits. Memory address; valid whenever `mem_req` is high.
- `data`: inout, 8 bits. Driven by the core only while `we` is high, high-Z otherwise. Read data is sampled when the handshake completes.
- `mem_req`: output, 1 bit. Memory transaction request.
- `we`: output, 1 bit. Write enable, high only during a store transaction.
- `mem_ready`: input, 1 bit. Memory acknowledge.

## Operation
- Byte 0 = `{op[3:0], r[3:0]}`; byte 1 = operand `k`. For register-source ops, the source is `s = k[7:4]` and `k[3:0]` is ignored.
- Opcodes:
  - 0 JMP: `pc <= k`.
  - 1 LD: `r <= mem[k]`.
  - 2 ST: `mem[k] <= r`.
  - 3 ADD: `r <= r + s`.
  - 4 MOV: `r <= s`.
  - 5 LDI: `r <= k`.
  - 6 SUB: `r <= r - s`.
  - 7 AND, 8 OR, 9 XOR: `r <= r op s`.
  - A JZ: `pc <= k` if zero flag Z == 1.
  - B–F: NOP.
- All arithmetic is 8-bit modulo 256; carry is discarded.
- Z is updated only by ADD/SUB/AND/OR/XOR/LD/LDI/MOV, set when the result == 0.
- `pc` advances by 2 after each non-taken instruction and wraps 0xFE→0x00. An operand fetch at 0xFF wraps to address 0x00.
- States:
  - FETCH_OP (access at `pc`) → FETCH_ARG (access at `pc+1`) → EXEC.
  - EXEC → MEM for LD/ST; → WB otherwise.
  - MEM → WB.
  - WB → FETCH_OP.
- Unknown opcodes pass through EXEC and WB with no state change except `pc += 2`.
- Register file: 16×8 bits, written only in WB, 1 write port and 2 read ports.

## Timing
- Memory access:
  - Drive `addr` and `mem_req=1` (plus `we` and `data` for ST) from a registered output.
  - Hold them until an edge where `mem_ready` is sampled high with `mem_req` high; capture `data` on that edge.
  - Then drop `mem_req` and `we` for at least one full cycle before the next request.
  - `mem_ready` is ignored while `mem_req` is low.
- The memory acknowledges one or more cycles after the request; the core tolerates any wait count and never times out.
- A write is committed by memory on edges where `we` is high. `data` and `addr` are stable for the whole write.
- Reset values, applied on a rising edge with `rst=1` and overriding any in-flight transaction (abandoned, no completion):
  - `pc=0`, all registers 0, Z=0.
  - `mem_req=0`, `we=0`, `addr=0`, `data` high-Z.
  - state FETCH_OP.
- The first request is raised on the first edge after `rst` falls.
- Minimum instruction latency with a 1-cycle-ack memory:
  - ALU/JMP: 2 accesses (3 cycles each incl. gap) + EXEC + WB.
  - LD/ST: add one more access.

## Structure
- Package `eight_bit_pkg`: opcode localparams, state enum, register-index width (4), data/address width (8).
- Sub-module `eight_bit_writeback`: contains the register file `reg_file[0:15]`, two async read ports, one sync write port, and synchronous reset clearing all entries.
- The top level holds the FSM, pc, instruction/operand latches, ALU and bus drivers.

## Test plan
- Reset:
  - Hold `rst` for 2 edges, then release.
  - Required: `mem_req=0`, `we=0` during reset; first request at `addr=0x00`; all registers 0.
- Fibonacci program at 0x00 (`50 01 51 00 20 E0 42 00 30 10 41 20 00 04`), 1-cycle-ack memory:
  - Successive writes to 0xE0 are 1,1,2,3,5,8,13,21,34,55,89,144,233,121 (mod-256 wrap).
  - JMP returns to 0x04 each loop.
- Handshake stretch:
  - Same program with `mem_ready` delayed 3 cycles.
  - Required: identical write sequence; `addr`/`we`/`data` stable while waiting; `data` high-Z whenever `we=0`.
- LD/ST and SUB:
  - Program `5F 80 2F F0 13 F0 63 30`.
  - Required: r3 = 0x80 after LD; r3 = 0x00 after SUB; Z=1.
- JZ:
  - With Z=1, `A0 40` jumps to 0x40.
  - With Z=0, it falls through to `pc+2`.
  - Unknown opcode `F0 00` only advances `pc` by 2.
- Mid-instruction reset:
  - Assert `rst` while waiting on `mem_ready` during ST.
  - Required: `we` and `mem_req` drop on that edge; memory is not written afterwards; execution restarts at 0x00.

Source files
------------

// File: rtl/eight_bit_pkg.sv
// eight_bit shared definitions: widths, opcodes, FSM states.
// Imported by the core and its register-file writeback block.
package eight_bit_pkg;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RW = 4;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_FETCH_ARG,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  // Ops that write r also update Z.
  function automatic logic writes_reg(
    input logic [3:0] op
  );
    return (op == OP_LD)  || (op == OP_LDI) ||
           (op == OP_MOV) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/eight_bit_writeback.sv
// eight_bit register file: 16x8, two async reads,
// one synchronous write, synchronous clear on reset.
module eight_bit_writeback
  import eight_bit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [RW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [RW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] reg_file [0:15];

  assign rd_data_a = reg_file[rd_addr_a];
  assign rd_data_b = reg_file[rd_addr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wr_en) begin
      reg_file[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/eight_bit.sv
// eight_bit core: multicycle FSM, pc, instruction latches,
// ALU and a registered request/ready memory bus.
module eight_bit
  import eight_bit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          mem_req,
  output logic          we,
  input  logic          mem_ready
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] k_q, k_d;
  logic [DW-1:0] res_q, res_d;
  logic          z_q, z_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [3:0]    op;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic          rf_we;
  logic          done;

  assign op   = ir_q[7:4];
  assign rd   = ir_q[3:0];
  assign rs   = k_q[7:4];
  assign done = req_q && mem_ready;

  assign addr    = addr_q;
  assign mem_req = req_q;
  assign we      = we_q;
  assign data    = we_q ? dout_q : 'z;

  eight_bit_writeback u_wb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rf_we),
    .wr_addr   (rd),
    .wr_data   (res_q),
    .rd_addr_a (rd),
    .rd_data_a (ra),
    .rd_addr_b (rs),
    .rd_data_b (rb)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    k_d     = k_q;
    res_d   = res_q;
    z_d     = z_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_FETCH_OP: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end else if (done) begin
          req_d   = 1'b0;
          ir_d    = data;
          state_d = S_FETCH_ARG;
        end
      end
      S_FETCH_ARG: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q + 8'd1;
        end else if (done) begin
          req_d   = 1'b0;
          k_d     = data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op)
          OP_ADD:  res_d = ra + rb;
          OP_SUB:  res_d = ra - rb;
          OP_AND:  res_d = ra & rb;
          OP_OR:   res_d = ra | rb;
          OP_XOR:  res_d = ra ^ rb;
          OP_MOV:  res_d = rb;
          OP_LDI:  res_d = k_q;
          default: res_d = res_q;
        endcase
        state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = k_q;
          we_d   = (op == OP_ST);
          dout_d = ra;
        end else if (done) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_WB;
          if (op == OP_LD) begin
            res_d = data;
          end
        end
      end
      S_WB: begin
        if (writes_reg(op)) begin
          rf_we = 1'b1;
          z_d   = (res_q == '0);
        end
        if (op == OP_JMP || (op == OP_JZ && z_q)) begin
          pc_d = k_q;
        end else begin
          pc_d = pc_q + 8'd2;
        end
        state_d = S_FETCH_OP;
      end
      default: state_d = S_FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH_OP;
      pc_q    <= '0;
      ir_q    <= '0;
      k_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      k_q     <= k_d;
      res_q   <= res_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_eight_bit.sv
// Directed bench for eight_bit: reset, Fibonacci loop, slow
// memory, LD/ST/SUB, JZ/NOP and reset during a pending store.
module tb_eight_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr;
  wire  [7:0] data;
  logic       mem_req;
  logic       we;
  logic       mem_ready;

  logic [7:0] rom [0:255];
  logic [7:0] ram [0:255];
  logic [7:0] rd_val;
  int         delay = 1;
  int         cnt = 0;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] wa [$];
  logic [7:0] wd [$];
  int         we_edges = 0;
  int         bus_err = 0;
  int         stab_err = 0;
  bit         chk_stab = 0;
  bit         p_wait = 0;
  logic [7:0] p_addr, p_data;
  logic       p_we;

  eight_bit u_dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data      (data),
    .mem_req   (mem_req),
    .we        (we),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  assign rd_val    = (addr >= 8'hE0) ? ram[addr] : rom[addr];
  assign data      = we ? 8'hzz : rd_val;
  assign mem_ready = mem_req && (cnt >= delay);

  always @(posedge clk) begin
    if (!mem_req || mem_ready) cnt <= 0;
    else cnt <= cnt + 1;
    if (we) ram[addr] <= data;
  end

  always @(negedge clk) begin
    if (mem_req && we && mem_ready) begin
      wa.push_back(addr);
      wd.push_back(data);
    end
    if (we === 1'b1) we_edges++;
    if (we === 1'b0 && data !== rd_val) bus_err++;
    if (chk_stab && p_wait &&
        (addr !== p_addr || we !== p_we ||
         (we && data !== p_data))) stab_err++;
    p_wait = mem_req && !mem_ready && !rst;
    p_addr = addr;
    p_we   = we;
    p_data = data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic next_read(input logic [7:0] exp,
                           input string tag);
    logic [7:0] a = 8'h00;
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_req && mem_ready && !we) begin
        a = addr;
        got = 1;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    chk(tag, {23'd0, got, a}, {23'd0, 1'b1, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_fib();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]  = 8'h50; rom[1]  = 8'h01;
    rom[2]  = 8'h51; rom[3]  = 8'h00;
    rom[4]  = 8'h20; rom[5]  = 8'hE0;
    rom[6]  = 8'h42; rom[7]  = 8'h00;
    rom[8]  = 8'h30; rom[9]  = 8'h10;
    rom[10] = 8'h41; rom[11] = 8'h20;
    rom[12] = 8'h00; rom[13] = 8'h04;
  endtask

  task automatic run_fib(input string tag);
    logic [7:0] fib [14] = '{8'd1, 8'd1, 8'd2, 8'd3,
      8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55,
      8'd89, 8'd144, 8'd233, 8'd121};
    int base = wa.size();
    for (int i = 0; i < 14; i++) begin
      next_read(8'(i), {tag, "_fetch"});
    end
    next_read(8'h04, {tag, "_jmp_back"});
    for (int c = 0; c < 4000 && wa.size() < base + 14; c++) begin
      @(posedge clk);
    end
    for (int i = 0; i < 14; i++) begin
      if (base + i < wa.size()) begin
        chk($sformatf("%s_wr%0d", tag, i),
            {16'd1, wa[base+i], wd[base+i]},
            {16'd1, 8'hE0, fib[i]});
      end else begin
        chk($sformatf("%s_wr%0d", tag, i),
            32'(base + i - wa.size()), 32'hFFFF_FFFF);
      end
    end
  endtask

  initial begin
    logic any;
    int base;
    int snap;
    bit got;

    // Reset behaviour and first request
    load_fib();
    delay = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      any = any | (|u_dut.u_wb.reg_file[i]);
    end
    chk("rst_regs", {31'd0, any}, 32'd0);
    chk("rst_z", {31'd0, u_dut.z_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_req", {23'd0, mem_req, addr}, {23'd0, 1'b1, 8'h00});

    // Fibonacci with one-cycle ack
    run_fib("fib1");

    // Fibonacci with stretched ack
    do_reset();
    delay = 3;
    chk_stab = 1;
    @(negedge clk);
    rst = 1'b0;
    run_fib("fib3");
    chk_stab = 0;
    chk("stretch_stable", stab_err, 0);

    // LD/ST/SUB, JZ taken/not taken, unknown opcode
    do_reset();
    delay = 2;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]  = 8'h5F; rom[1]  = 8'h80;
    rom[2]  = 8'h2F; rom[3]  = 8'hF0;
    rom[4]  = 8'h13; rom[5]  = 8'hF0;
    rom[6]  = 8'h63; rom[7]  = 8'h30;
    rom[8]  = 8'hA0; rom[9]  = 8'h40;
    rom[64] = 8'h54; rom[65] = 8'h01;
    rom[66] = 8'hA0; rom[67] = 8'h80;
    rom[68] = 8'hF0; rom[69] = 8'h00;
    rom[70] = 8'h00; rom[71] = 8'h46;
    base = wa.size();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_read(8'(i), "ldst_fetch");
    end
    next_read(8'hF0, "ld_addr");
    chk("st_write",
        (base < wa.size()) ? {16'd0, wa[base], wd[base]} : 32'hDEAD,
        {16'd0, 8'hF0, 8'h80});
    next_read(8'h06, "fetch_06");
    chk("ld_r3", u_dut.u_wb.reg_file[3], 8'h80);
    next_read(8'h07, "fetch_07");
    next_read(8'h08, "fetch_08");
    chk("sub_r3", u_dut.u_wb.reg_file[3], 8'h00);
    chk("sub_z", {31'd0, u_dut.z_q}, 32'd1);
    next_read(8'h09, "fetch_09");
    next_read(8'h40, "jz_taken");
    next_read(8'h41, "fetch_41");
    next_read(8'h42, "fetch_42");
    chk("ldi_z", {31'd0, u_dut.z_q}, 32'd0);
    next_read(8'h43, "fetch_43");
    next_read(8'h44, "jz_not_taken");
    next_read(8'h45, "fetch_45");
    next_read(8'h46, "nop_advance");
    chk("nop_r0", u_dut.u_wb.reg_file[0], 8'h00);
    chk("nop_rf", u_dut.u_wb.reg_file[15], 8'h80);
    chk("nop_r4", u_dut.u_wb.reg_file[4], 8'h01);

    // Reset while a store waits on mem_ready
    do_reset();
    delay = 30;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h5F; rom[1] = 8'h5A;
    rom[2] = 8'h2F; rom[3] = 8'hF1;
    base = wa.size();
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (we) got = 1;
    end
    chk("st_pending", {31'd0, got}, 32'd1);
    #1;
    rst = 1'b1;
    snap = we_edges;
    @(posedge clk);
    #1;
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("no_write_after", we_edges, snap);
    chk("no_completion", wa.size(), base);
    chk("abort_rf", u_dut.u_wb.reg_file[15], 8'h00);
    delay = 1;
    @(negedge clk);
    rst = 1'b0;
    next_read(8'h00, "restart_addr");
    chk("no_write_restart", we_edges, snap);

    chk("bus_hiz", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
